serial_byte_loader: RTL and testbench
=====================================

# serial_byte_loader

Upstream feeder for the 2-bit field splitter/combiner stage. Collects a serial bit stream, MSB first, into an 8-bit word. Holds the finished word in a one-entry output buffer and presents it with a valid/ready handshake. The splitter's 8-bit `in` bus is driven directly from `out_data`.

## Interface
- No parameters; word width is fixed at 8 bits to match the splitter input.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bit_in`  in  1  serial data bit, sampled when `bit_valid`=1.
- `bit_valid`  in  1  qualifies `bit_in`. There is no serial-side backpressure: every qualified bit is consumed.
- `out_data`  out  8  buffered word for the splitter.
- `out_valid`  out  1  `out_data` holds an unconsumed word.
- `out_ready`  in  1  downstream accepts the word this cycle.
- `overrun`  out  1  one-cycle pulse: a completed word was dropped.
- `parity_err`  out  1  one-cycle pulse: a frame failed parity. Tied 0 without `SERIAL_BYTE_PARITY_EN`.

## Operation
- Shift register `sh[7:0]`. On each accepted bit: `sh <= {sh[6:0], bit_in}`.
- Bit counter `cnt`, range 0..7 (0..8 with parity). It advances only on accepted bits.
- FSM states:
  - IDLE: `cnt`=0, no frame in progress. The first accepted bit moves the FSM to SHIFT.
  - SHIFT: collecting data bits 1..7. On the 8th data bit:
    - without parity: complete the frame and return to IDLE;
    - with parity: go to PARITY.
  - PARITY: the next accepted bit is the parity bit. The frame completes and the FSM returns to IDLE.
- Frame completion:
  - The word `{sh[6:0], last_bit}` is a candidate for the holding register.
  - If the buffer is empty, or is being consumed in the same cycle (`out_valid & out_ready`), load it and set `out_valid`=1.
  - Otherwise drop the candidate, keep the old word, and pulse `overrun`.
- Handshake:
  - A transfer occurs on any edge with `out_valid & out_ready`.
  - Consumption with no simultaneous completion clears `out_valid`.
  - `out_data` must not change while `out_valid`=1, except by a simultaneous consume-and-load.
- Gaps in `bit_valid` stall the frame indefinitely; no timeout.
- Reset mid-frame discards the partial word and any buffered word.

## Timing
- Reset values:
  - `out_data`=8'h00, `out_valid`=0, `overrun`=0, `parity_err`=0.
  - `cnt`=0, `sh`=8'h00, FSM=IDLE.
- Latency: `out_valid` rises on the clock edge that samples the final bit of the frame (8th data bit, or the parity bit). It is visible in the following cycle.
- Minimum frame period is 8 cycles (9 with parity). A downstream that asserts `out_ready` continuously never causes overrun.
- `overrun` and `parity_err` are registered and asserted for exactly one cycle, aligned with the completion edge.
- Consume, complete and load in the same cycle: `out_valid` stays 1, `out_data` takes the new word, no overrun.

## Configuration
- `SERIAL_BYTE_PARITY_EN` defined:
  - Frames are 9 bits: 8 data bits, then 1 even-parity bit.
  - Good parity (XOR of all 9 bits = 0): the word is buffered normally.
  - Bad parity: pulse `parity_err` and drop the word. The buffer is unchanged and `overrun` is not asserted.
- `SERIAL_BYTE_PARITY_EN` undefined:
  - Frames are 8 bits and the PARITY state is not built.
  - `parity_err` is constant 0.

## Test plan
- Reset, then shift 0,0,1,1,0,1,0,1 on consecutive cycles with `out_ready`=0 → `out_valid`=1 with `out_data`=8'h35. The splitter shows num1..num4 = 00,11,01,01. The word holds until `out_ready`=1, and `out_valid` drops the cycle after the transfer.
- Two back-to-back frames 8'hA5, 8'h3C with `out_ready` tied 1 → two transfers, 8 cycles apart, values A5 then 3C, `overrun` never set.
- Frame 8'hFF completes while 8'h0F is buffered and `out_ready`=0 → `overrun` pulses once, `out_data` stays 8'h0F.
- Same as the previous case, but `out_ready`=1 on the completion cycle → 0F transfers, `out_data` becomes FF, `out_valid` stays 1, no overrun.
- Deassert `rst_n` asynchronously after 4 bits of a frame → all outputs return to reset values immediately. A fresh 8-bit frame 8'h81 afterwards yields exactly 8'h81.
- With `SERIAL_BYTE_PARITY_EN`:
  - 8'h35 with parity bit 0 → buffered.
  - 8'h35 with parity bit 1 → `parity_err` pulses once, `out_valid` stays 0.

Source files
------------

// File: rtl/serial_byte_loader.sv
// Serial-to-parallel byte loader (MSB first) with a one-entry valid/ready output buffer.
// Optional even-parity framing is built when SERIAL_BYTE_PARITY_EN is defined.
module serial_byte_loader (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_in,
  input  logic       bit_valid,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overrun,
  output logic       parity_err
);

`ifdef SERIAL_BYTE_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

  state_t     state_r, state_s;
  logic [7:0] sh_r, sh_s;
  logic [3:0] cnt_r, cnt_s;
  logic [7:0] data_r, data_s;
  logic       valid_r, valid_s;
  logic       ovr_r, ovr_s;
  logic       done_s;
  logic       good_s;
  logic [7:0] word_s;
  logic       load_ok_s;
  logic       xfer_s;

`ifdef SERIAL_BYTE_PARITY_EN
  logic       perr_r, perr_s;

  function automatic logic even_parity_ok(input logic [7:0] d, input logic p);
    return ~((^d) ^ p);
  endfunction
`endif

  // Frame state, shift register and bit counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      sh_r    <= 8'h00;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_s;
      sh_r    <= sh_s;
      cnt_r   <= cnt_s;
    end
  end

  // Next-state logic and frame completion detection.
  always_comb begin
    state_s = state_r;
    sh_s    = sh_r;
    cnt_s   = cnt_r;
    done_s  = 1'b0;
    good_s  = 1'b1;
    word_s  = {sh_r[6:0], bit_in};
    case (state_r)
      IDLE: begin
        if (bit_valid) begin
          sh_s    = {sh_r[6:0], bit_in};
          cnt_s   = 4'd1;
          state_s = SHIFT;
        end else begin
          cnt_s   = 4'd0;
        end
      end
      SHIFT: begin
        if (bit_valid) begin
          sh_s = {sh_r[6:0], bit_in};
          if (cnt_r == 4'd7) begin
`ifdef SERIAL_BYTE_PARITY_EN
            cnt_s   = 4'd8;
            state_s = PARITY;
`else
            cnt_s   = 4'd0;
            state_s = IDLE;
            done_s  = 1'b1;
`endif
          end else begin
            cnt_s = cnt_r + 4'd1;
          end
        end else begin
          sh_s = sh_r;
        end
      end
`ifdef SERIAL_BYTE_PARITY_EN
      // The parity bit is not shifted in: sh_r already holds all 8 data bits.
      PARITY: begin
        if (bit_valid) begin
          word_s  = sh_r;
          good_s  = even_parity_ok(sh_r, bit_in);
          done_s  = 1'b1;
          cnt_s   = 4'd0;
          state_s = IDLE;
        end else begin
          word_s  = sh_r;
        end
      end
`endif
      default: begin
        state_s = IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Output buffer: load on completion if empty or draining this cycle, else drop.
  always_comb begin
    xfer_s    = valid_r & out_ready;
    load_ok_s = ~valid_r | out_ready;
    data_s    = data_r;
    valid_s   = valid_r;
    ovr_s     = done_s & good_s & ~load_ok_s;
    if (done_s && good_s && load_ok_s) begin
      data_s  = word_s;
      valid_s = 1'b1;
    end else if (xfer_s) begin
      valid_s = 1'b0;
    end else begin
      valid_s = valid_r;
    end
  end

`ifdef SERIAL_BYTE_PARITY_EN
  // Parity failure pulse.
  always_comb begin
    perr_s = done_s & ~good_s;
  end
`endif

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_r  <= 8'h00;
      valid_r <= 1'b0;
      ovr_r   <= 1'b0;
    end else begin
      data_r  <= data_s;
      valid_r <= valid_s;
      ovr_r   <= ovr_s;
    end
  end

`ifdef SERIAL_BYTE_PARITY_EN
  // Registered parity error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perr_r <= 1'b0;
    end else begin
      perr_r <= perr_s;
    end
  end
  assign parity_err = perr_r;
`else
  assign parity_err = 1'b0;
`endif

  assign out_data  = data_r;
  assign out_valid = valid_r;
  assign overrun   = ovr_r;

endmodule

// File: tb/tb_serial_byte_loader.sv
// Scoreboard bench for serial_byte_loader: expected words queued at stimulus time,
// popped and compared on every observed transfer.
module tb_serial_byte_loader;

`ifdef SERIAL_BYTE_PARITY_EN
  localparam int FRAME = 9;
`else
  localparam int FRAME = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       bit_in = 1'b0;
  logic       bit_valid = 1'b0;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       overrun;
  logic       parity_err;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ovr_seen = 0, ovr_exp = 0;
  int par_seen = 0, par_exp = 0;
  logic [7:0] sb[$];
  int xfer_cyc[$];

  serial_byte_loader dut (
    .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transfer monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (overrun === 1'b1) ovr_seen++;
      if (parity_err === 1'b1) par_seen++;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        xfer_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          check_eq("sb_nonempty", 32'(sb.size()), 32'd1);
        end else begin
          check_eq("xfer_data", {24'd0, out_data}, {24'd0, sb.pop_front()});
        end
      end
    end
  end

  task automatic send_bit(input logic b);
    @(posedge clk); #1;
    bit_in = b;
    bit_valid = 1'b1;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    bit_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rdy_last);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
`ifdef SERIAL_BYTE_PARITY_EN
    send_bit(^b);
`endif
    if (rdy_last) out_ready = 1'b1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #12;
    check_eq("rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_data", {24'd0, out_data}, 32'h00);
    check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
    check_eq("rst_parity_err", {31'd0, parity_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic frame, held until accepted
    sb.push_back(8'h35);
    send_byte(8'h35, 1'b0);
    idle();
    check_eq("t1_valid", {31'd0, out_valid}, 32'd1);
    check_eq("t1_data", {24'd0, out_data}, 32'h35);
    check_eq("t1_num1", {30'd0, out_data[7:6]}, 32'd0);
    check_eq("t1_num2", {30'd0, out_data[5:4]}, 32'd3);
    check_eq("t1_num3", {30'd0, out_data[3:2]}, 32'd1);
    check_eq("t1_num4", {30'd0, out_data[1:0]}, 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("t1_hold_valid", {31'd0, out_valid}, 32'd1);
    check_eq("t1_hold_data", {24'd0, out_data}, 32'h35);
    drain();
    check_eq("t1_valid_drop", {31'd0, out_valid}, 32'd0);

    // Back-to-back frames with continuous ready
    out_ready = 1'b1;
    xfer_cyc.delete();
    sb.push_back(8'hA5);
    sb.push_back(8'h3C);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h3C, 1'b0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("t2_xfers", 32'(xfer_cyc.size()), 32'd2);
    if (xfer_cyc.size() == 2)
      check_eq("t2_spacing", 32'(xfer_cyc[1] - xfer_cyc[0]), 32'(FRAME));
    check_eq("t2_overrun", 32'(ovr_seen), 32'(ovr_exp));

    // Overrun: completion while the buffer is full and not draining
    sb.push_back(8'h0F);
    send_byte(8'h0F, 1'b0);
    idle();
    send_byte(8'hFF, 1'b0);
    idle();
    ovr_exp++;
    check_eq("t3_overrun", {31'd0, overrun}, 32'd1);
    check_eq("t3_data", {24'd0, out_data}, 32'h0F);
    check_eq("t3_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;
    check_eq("t3_overrun_pulse", {31'd0, overrun}, 32'd0);
    drain();

    // Consume and load in the same cycle
    sb.push_back(8'h0F);
    send_byte(8'h0F, 1'b0);
    idle();
    sb.push_back(8'hFF);
    send_byte(8'hFF, 1'b1);
    idle();
    check_eq("t4_valid", {31'd0, out_valid}, 32'd1);
    check_eq("t4_data", {24'd0, out_data}, 32'hFF);
    check_eq("t4_overrun", {31'd0, overrun}, 32'd0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("t4_drained", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset mid-frame with a buffered word
    sb.push_back(8'h55);
    send_byte(8'h55, 1'b0);
    idle();
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    bit_valid = 1'b0;
    sb.delete();
    check_eq("t5_rst_valid", {31'd0, out_valid}, 32'd0);
    check_eq("t5_rst_data", {24'd0, out_data}, 32'h00);
    check_eq("t5_rst_overrun", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(8'h81);
    send_byte(8'h81, 1'b0);
    idle();
    check_eq("t5_valid", {31'd0, out_valid}, 32'd1);
    check_eq("t5_data", {24'd0, out_data}, 32'h81);
    drain();

`ifdef SERIAL_BYTE_PARITY_EN
    // Parity: good frame buffered, bad frame dropped with a pulse
    sb.push_back(8'h35);
    for (int i = 7; i >= 0; i--) send_bit(8'h35 >> i);
    send_bit(1'b0);
    idle();
    check_eq("p_good_valid", {31'd0, out_valid}, 32'd1);
    check_eq("p_good_data", {24'd0, out_data}, 32'h35);
    drain();
    for (int i = 7; i >= 0; i--) send_bit(8'h35 >> i);
    send_bit(1'b1);
    idle();
    par_exp++;
    check_eq("p_bad_err", {31'd0, parity_err}, 32'd1);
    check_eq("p_bad_valid", {31'd0, out_valid}, 32'd0);
    check_eq("p_bad_overrun", {31'd0, overrun}, 32'd0);
    @(posedge clk); #1;
    check_eq("p_bad_pulse", {31'd0, parity_err}, 32'd0);
`endif

    repeat (3) @(posedge clk);
    #1;
    check_eq("sb_empty_end", 32'(sb.size()), 32'd0);
    check_eq("overrun_count", 32'(ovr_seen), 32'(ovr_exp));
    check_eq("parity_err_count", 32'(par_seen), 32'(par_exp));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
